// File: rtl/tx_byte_feeder_if.sv
// Producer/transmitter-side bundle for tx_byte_feeder.
// The feeder itself takes the slave view.
interface tx_byte_feeder_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  ovf_clr;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  TxD_start;
    logic [7:0]            TxD_data;
    logic                  TxD_busy;

    modport master (
        output wr_en, wr_data, ovf_clr, TxD_busy,
        input  full, empty, count, overflow, TxD_start, TxD_data
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr, TxD_busy,
        output full, empty, count, overflow, TxD_start, TxD_data
    );
endinterface

// File: rtl/tx_byte_feeder.sv
// Byte FIFO in front of the UART transmitter: one TxD_start pulse per stored
// byte, never issued while the transmitter reports busy.
module tx_byte_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    tx_byte_feeder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic                  r_tx_start;
    logic [7:0]            r_tx_data;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;

    // Push/pop qualification and next occupancy; acceptance is judged on the registered full flag.
    always_comb begin
        w_push      = bus.wr_en && !r_full;
        w_drop      = bus.wr_en && r_full;
        w_pop       = (r_state == ST_IDLE) && !r_empty && !bus.TxD_busy;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Handshake FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.TxD_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else begin
                    w_state_nxt = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.TxD_busy) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage array; contents are only read for occupied slots, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
            r_empty <= (w_count_nxt == CNT_ZERO);
        end
    end

    // Sticky overflow: a drop on the same edge wins over a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    // Start pulse and data to the transmitter; data holds until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign bus.full      = r_full;
    assign bus.empty     = r_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.TxD_start = r_tx_start;
    assign bus.TxD_data  = r_tx_data;
endmodule
